mac_seq: RTL and testbench

Dot-product sequencer for the 8-bit × 8-bit MAC datapath. It accepts a job of `len` operand pairs and clears the 22-bit accumulator at job start. It streams the pairs in through a valid/ready handshake, then presents the final sum with a sticky overflow flag through a result handshake. It sits between an operand source (FIFO or memory reader) and the result consumer, and owns all clear/enable control of the MAC.

---
 rtl/mac_pkg.sv | 12 +
 rtl/mac_core.sv | 53 +++++
 rtl/mac_seq.sv | 90 +++++++++
 tb/tb_mac_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC datapath and its sequencer.
package mac_pkg;
    localparam int OPND_W = 8;
    localparam int ACC_W  = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/mac_core.sv
// 8x8 multiply-accumulate datapath: operand registers, multiplier, accumulator with carry-out.
module mac_core
    import mac_pkg::*;
#(
    parameter int ACC_W = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              carry
);
    localparam int PROD_W = 2 * OPND_W;

    logic [OPND_W-1:0] a_reg;
    logic [OPND_W-1:0] b_reg;
    logic              prod_vld_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [PROD_W-1:0] product;
    logic [ACC_W:0]    sum;

    assign product = a_reg * b_reg;
    assign sum     = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    // Carry only counts on an edge where the product is actually added.
    assign carry   = prod_vld_reg & sum[ACC_W];
    assign acc     = acc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            prod_vld_reg <= 1'b0;
            acc_reg      <= '0;
        end else begin
            if (clear) begin
                acc_reg      <= '0;
                prod_vld_reg <= 1'b0;
            end else begin
                if (prod_vld_reg) begin
                    acc_reg <= sum[ACC_W-1:0];
                end
                prod_vld_reg <= load;
            end
            if (load) begin
                a_reg <= a;
                b_reg <= b;
            end
        end
    end
endmodule

// File: rtl/mac_seq.sv
// Dot-product sequencer: streams len operand pairs into mac_core and hands off the sum and sticky overflow.
module mac_seq
    import mac_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int ACC_W = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  result,
    output logic              ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
);
    state_t           state_reg;
    state_t           state_next;
    logic [LEN_W-1:0] count_reg;
    logic             ovf_reg;
    logic             clear;
    logic             accept;
    logic             carry;
    logic [ACC_W-1:0] acc;

    assign clear  = (state_reg == IDLE) && start;
    assign accept = (state_reg == RUN) && in_valid;

    mac_core #(.ACC_W(ACC_W)) u_core (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .load  (accept),
        .a     (a),
        .b     (b),
        .acc   (acc),
        .carry (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (len == '0) ? DONE : RUN;
            RUN:     if (in_valid && count_reg == LEN_W'(1)) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == RUN);
        res_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            if (clear) begin
                count_reg <= len;
            end else if (accept) begin
                count_reg <= count_reg - LEN_W'(1);
            end
            if (clear) begin
                ovf_reg <= 1'b0;
            end else if (carry) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign result = acc;
    assign ovf    = ovf_reg;
endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: table of whole jobs plus hand-written handshake and reset corner cases.
module tb_mac_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] result;
    logic        ovf;
    logic        res_valid;
    logic        res_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .ovf       (ovf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    typedef struct {
        int       n;
        int       a0;
        int       b0;
        int       step;
        int       gap;
        longint   exp_result;
        int       exp_ovf;
        int       exp_lat;
    } job_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(inout int cycles);
        @(posedge clk);
        #1;
        cycles++;
    endtask

    // Runs a complete job; pair i is (a0 + i*step, b0 + i*step) with gap idle cycles after each pair.
    task automatic run_job(input job_t j, input string tag);
        int cycles = 0;
        int ready_bad = 0;
        start = 1'b1;
        len   = 8'(j.n);
        tick(cycles);
        start = 1'b0;
        for (int i = 0; i < j.n; i++) begin
            if (!in_ready) ready_bad++;
            in_valid = 1'b1;
            a = 8'(j.a0 + i * j.step);
            b = 8'(j.b0 + i * j.step);
            tick(cycles);
            in_valid = 1'b0;
            a = 8'hxx;
            b = 8'hxx;
            if (i != j.n - 1) begin
                for (int g = 0; g < j.gap; g++) begin
                    if (!in_ready) ready_bad++;
                    tick(cycles);
                end
            end
        end
        while (!res_valid && cycles < 400) tick(cycles);
        chk({tag, " res_valid"}, longint'(res_valid), 1);
        if (j.exp_lat >= 0) chk({tag, " latency"}, cycles, j.exp_lat);
        chk({tag, " in_ready during RUN"}, ready_bad, 0);
        chk({tag, " result"}, longint'(result), j.exp_result);
        chk({tag, " ovf"}, longint'(ovf), j.exp_ovf);
        $display("job %s: len=%0d result=%0d ovf=%0d cycles=%0d", tag, j.n, result, ovf, cycles);
        res_ready = 1'b1;
        tick(cycles);
        res_ready = 1'b0;
        chk({tag, " busy after res_ready"}, longint'(busy), 0);
    endtask

    job_t jobs[7];

    initial begin
        int cyc = 0;
        int hold_bad;
        jobs[0] = '{4,   1,   2,   2, 0, 100,     0, 6};
        jobs[1] = '{3,   255, 255, 0, 2, 195075,  0, -1};
        jobs[2] = '{65,  255, 255, 0, 0, 32321,   1, 67};
        jobs[3] = '{1,   2,   3,   0, 0, 6,       0, 3};
        jobs[4] = '{0,   0,   0,   0, 0, 0,       0, 1};
        jobs[5] = '{64,  255, 255, 0, 0, 4161600, 0, 66};
        jobs[6] = '{2,   200, 100, 0, 1, 40000,   0, -1};

        rst = 1'b1; start = 1'b0; len = '0; a = '0; b = '0;
        in_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", longint'(in_ready), 0);
        chk("reset res_valid", longint'(res_valid), 0);
        chk("reset busy", longint'(busy), 0);
        chk("reset result", longint'(result), 0);
        chk("reset ovf", longint'(ovf), 0);
        rst = 1'b0;
        tick(cyc);

        for (int k = 0; k < 7; k++) begin
            run_job(jobs[k], $sformatf("vec%0d", k));
        end

        // Zero-length job held in DONE for 5 cycles while a second start is offered.
        start = 1'b1; len = 8'd3;
        tick(cyc);
        len = 8'd0;
        chk("len0 guard setup", longint'(in_ready), 1);
        // That start had len=3; finish it to reach IDLE before the real zero-length case.
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 8'd1; b = 8'd1;
            tick(cyc);
        end
        in_valid = 1'b0;
        tick(cyc);
        chk("len3 result", longint'(result), 3);
        res_ready = 1'b1; tick(cyc); res_ready = 1'b0;
        start = 1'b1; len = 8'd0;
        tick(cyc);
        chk("len0 res_valid after 1 cycle", longint'(res_valid), 1);
        chk("len0 result", longint'(result), 0);
        len = 8'd3;
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick(cyc);
            if (!res_valid || in_ready || result != 22'd0 || ovf) hold_bad++;
        end
        start = 1'b0;
        chk("len0 hold stable", hold_bad, 0);
        $display("job len0-hold: result=%0d res_valid=%0d", result, res_valid);
        res_ready = 1'b1; tick(cyc); res_ready = 1'b0;
        chk("len0 idle after res_ready", longint'(busy), 0);

        // Asynchronous reset mid-RUN after 2 of 5 pairs.
        start = 1'b1; len = 8'd5;
        tick(cyc);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 8'd10; b = 8'd10;
            tick(cyc);
        end
        in_valid = 1'b0;
        tick(cyc);
        chk("pre-reset partial result", longint'(result), 200);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst in_ready", longint'(in_ready), 0);
        chk("async rst busy", longint'(busy), 0);
        chk("async rst res_valid", longint'(res_valid), 0);
        chk("async rst result", longint'(result), 0);
        chk("async rst ovf", longint'(ovf), 0);
        $display("async reset mid-RUN: busy=%0d result=%0d", busy, result);
        tick(cyc);
        rst = 1'b0;
        tick(cyc);
        run_job('{1, 9, 9, 0, 0, 81, 0, 3}, "post-reset");

        // res_ready and start together in DONE: start ignored, next-cycle start accepted.
        start = 1'b1; len = 8'd1;
        tick(cyc);
        start = 1'b0;
        in_valid = 1'b1; a = 8'd7; b = 8'd8;
        tick(cyc);
        in_valid = 1'b0;
        tick(cyc);
        chk("done-race res_valid", longint'(res_valid), 1);
        chk("done-race result", longint'(result), 56);
        res_ready = 1'b1; start = 1'b1; len = 8'd1;
        tick(cyc);
        res_ready = 1'b0;
        chk("done-race start ignored busy", longint'(busy), 0);
        chk("done-race start ignored in_ready", longint'(in_ready), 0);
        tick(cyc);
        start = 1'b0;
        chk("done-race later start accepted", longint'(in_ready), 1);
        in_valid = 1'b1; a = 8'd4; b = 8'd5;
        tick(cyc);
        in_valid = 1'b0;
        tick(cyc);
        chk("done-race second result", longint'(result), 20);
        chk("done-race second res_valid", longint'(res_valid), 1);
        $display("job done-race: result=%0d", result);
        res_ready = 1'b1; tick(cyc); res_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
